// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - streaming CRC engine folding DATA_W/8 bytes per beat, partial last beat
// Define CRC_CHECK_EN to add the crc_ok residue checker.
module crc_stream_engine #(
  parameter int          DATA_W  = 8,
  parameter int          CRC_W   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT = 32'hFFFFFFFF,
  parameter logic        REFLECT = 1'b1,
  parameter logic [31:0] RESIDUE = 32'hC704DD7B
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strt,
  input  logic [DATA_W-1:0]   data,
  input  logic                updatecrc,
  input  logic                last,
  input  logic [DATA_W/8-1:0] byte_en,
  output logic                busy,
  output logic [CRC_W-1:0]    result,
  output logic                result_valid
`ifdef CRC_CHECK_EN
  ,
  output logic                crc_ok
`endif
);

  localparam int               NB       = DATA_W / 8;
  localparam logic [CRC_W-1:0] POLY_T   = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_T   = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_T    = XOR_OUT[CRC_W-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic             accept, finalise;
  logic [CRC_W-1:0] crc_reg, crc_next, crc_rev, crc_out;

  // strt qualifies a beat in any state, so SOP beats fold from INIT
  assign accept   = updatecrc & (strt | (state == RUN));
  assign finalise = accept & last;

  // Register is kept in normal (MSB-first) form; REFLECT only changes bit feed order.
  always_comb begin : fold
    logic [CRC_W-1:0] c;
    logic             run;
    logic             bit_in;
    logic             fb;
    c      = strt ? INIT_T : crc_reg;
    run    = 1'b1;
    bit_in = 1'b0;
    fb     = 1'b0;
    for (int i = 0; i < NB; i++) begin
      run = run & (byte_en[i] | ~last);
      if (run) begin
        for (int b = 0; b < 8; b++) begin
          bit_in = REFLECT ? data[8*i+b] : data[8*i+7-b];
          fb     = c[CRC_W-1] ^ bit_in;
          c      = (c << 1) ^ (fb ? POLY_T : '0);
        end
      end
    end
    crc_next = c;
  end

  always_comb begin
    crc_rev = '0;
    for (int k = 0; k < CRC_W; k++) crc_rev[k] = crc_next[CRC_W-1-k];
  end

  assign crc_out = (REFLECT ? crc_rev : crc_next) ^ XOR_T;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == RUN);
    if (strt)          state_nxt = (updatecrc && last) ? DONE : RUN;
    else if (finalise) state_nxt = DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg      <= INIT_T;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= finalise;
      if (accept)    crc_reg <= crc_next;
      else if (strt) crc_reg <= INIT_T;
      if (finalise)  result <= crc_out;
    end
  end

`ifdef CRC_CHECK_EN
  localparam logic [CRC_W-1:0] RESIDUE_T = RESIDUE[CRC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           crc_ok <= 1'b0;
    else if (finalise) crc_ok <= (crc_next == RESIDUE_T);
    else if (strt)     crc_ok <= 1'b0;
  end
`else
  logic unused_residue;
  assign unused_residue = ^RESIDUE;
`endif

endmodule
